// File: rtl/fetch_stage_pkg.sv
// Shared RV32 fetch/decode definitions: opcodes, NOP encoding, B-immediate helpers, IF/ID record.
package fetch_stage_pkg;

    localparam logic [6:0]  OPC_BRANCH  = 7'b1100011;
    localparam logic [31:0] RV_NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic        valid;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic        pred;
    } if_id_t;

    function automatic logic [31:0] b_imm(input logic [31:0] inst);
        return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

    // Backward conditional branch: the sign bit of the B-immediate is the instruction MSB.
    function automatic logic is_backward_branch(input logic [31:0] inst);
        return (inst[6:0] == OPC_BRANCH) && inst[31];
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: captures the fetched record, holds on stall, invalidates to NOP.
module fetch_stage_if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INST = RV_NOP_INST
) (
    input  logic   clk,
    input  logic   i_rst,
    input  logic   i_hold,
    input  logic   i_invalidate,
    input  if_id_t i_data,
    output if_id_t o_data
);

    localparam if_id_t INVALID = '{valid: 1'b0, inst: NOP_INST, pc: 32'd0,
                                   pc_plus4: 32'd0, pred: 1'b0};

    if_id_t data_d;
    if_id_t data_q;

    // Invalidate wins over hold so a redirect during a stall still kills the wrong-path word.
    always_comb begin
        // NOTE: default assignment first keeps this block free of inferred latches.
        data_d = data_q;
        if (i_invalidate) begin
            data_d = INVALID;
        end else if (!i_hold) begin
            data_d = i_data;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous here, so it is tested inside the clocked block only.
        if (i_rst) begin
            data_q <= INVALID;
        end else begin
            // NOTE: state registers use non-blocking assignment so all flops update together.
            data_q <= data_d;
        end
    end

    assign o_data = data_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection and IF/ID capture.
// Optional backward-branch static prediction enabled by defining FETCH_STATIC_PREDICT_EN.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter logic [31:0] NOP_INST   = RV_NOP_INST
) (
    input  logic        clk,
    input  logic        i_rst,
    output logic [31:0] o_imem_raddr,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_id_valid,
    output logic [31:0] o_id_inst,
    output logic [31:0] o_id_pc,
    output logic [31:0] o_id_pc_plus4,
    output logic        o_id_pred_taken,
    output logic        o_misaligned
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_plus4;
    logic [31:0] next_seq;
    logic        pred;
    logic        misaligned_q, misaligned_d;
    if_id_t      if_id_in, if_id_out;

    assign pc_plus4 = pc_q + 32'd4;

`ifdef FETCH_STATIC_PREDICT_EN
    logic [31:0] br_target;

    assign br_target = pc_q + b_imm(i_imem_rdata);
    assign pred      = is_backward_branch(i_imem_rdata);
    // Word-align the predicted target; a halfword-only offset cannot leave PC misaligned.
    assign next_seq  = pred ? {br_target[31:2], 2'b00} : pc_plus4;
`else
    assign pred     = 1'b0;
    assign next_seq = pc_plus4;
`endif

    always_comb begin
        pc_d = pc_q;
        if (i_redirect) begin
            pc_d = {i_redirect_pc[31:2], 2'b00};
        end else if (!i_stall) begin
            pc_d = next_seq;
        end
    end

    assign misaligned_d = i_redirect && (|i_redirect_pc[1:0]);

    always_ff @(posedge clk) begin
        if (i_rst) begin
            pc_q         <= {RESET_ADDR[31:2], 2'b00};
            misaligned_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign if_id_in = '{valid: 1'b1, inst: i_imem_rdata, pc: pc_q,
                        pc_plus4: pc_plus4, pred: pred};

    fetch_stage_if_id_reg #(
        .NOP_INST(NOP_INST)
    ) u_if_id_reg (
        .clk         (clk),
        .i_rst       (i_rst),
        .i_hold      (i_stall),
        .i_invalidate(i_redirect || i_flush),
        .i_data      (if_id_in),
        .o_data      (if_id_out)
    );

    assign o_imem_raddr    = pc_q;
    assign o_id_valid      = if_id_out.valid;
    assign o_id_inst       = if_id_out.inst;
    assign o_id_pc         = if_id_out.pc;
    assign o_id_pc_plus4   = if_id_out.pc_plus4;
    assign o_id_pred_taken = if_id_out.pred;
    assign o_misaligned    = misaligned_q;

endmodule
